// File: rtl/d_ff.sv
// d_ff: parameterised D flip-flop with synchronous, active-high reset.
//
// Parameters
//   WIDTH     : data width in bits (1..64)
//   RESET_VAL : value loaded into q on a reset edge
//
// Ports
//   clk   : single clock; all state changes on its rising edge
//   reset : synchronous active-high reset, has priority over d
//   d     : data sampled at the rising clk edge
//   q     : registered state, driven straight from the flops
//
// q has no defined power-up value; it is X until the first rising edge.
`timescale 1ns/10ps

module d_ff #(
  parameter int                 WIDTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Reset is only looked at on the clock edge, so a reset pulse that rises
  // and falls between edges leaves the stored value untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: tb/tb_d_ff.sv
`timescale 1ns/10ps

module tb_d_ff;

  localparam logic [7:0] RV8 = 8'hA5;

  logic        clk;
  logic        reset;
  logic        d1;
  logic        q1;
  logic [7:0]  d8;
  logic [7:0]  q8;
  logic [63:0] newaddress;
  logic [63:0] oldaddress;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        q1;
    logic [7:0]  q8;
    logic [63:0] q64;
  } exp_t;

  exp_t sb[$];

  // Devices under test: default 1-bit flop, an 8-bit flop with a non-zero
  // reset value, and a 64-bit register built from 64 single-bit copies.
  d_ff u_dut1 (.clk(clk), .reset(reset), .d(d1), .q(q1));

  d_ff #(.WIDTH(8), .RESET_VAL(RV8)) u_dut8 (.clk(clk), .reset(reset), .d(d8), .q(q8));

  for (genvar gi = 0; gi < 64; gi++) begin : g_bits
    d_ff u_bit (.clk(clk), .reset(reset), .d(newaddress[gi]), .q(oldaddress[gi]));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: on an edge, reset forces the reset value, otherwise q
  // becomes whatever d held at that edge.
  function automatic exp_t model(input logic rst, input logic a, input logic [7:0] b,
                                 input logic [63:0] c);
    exp_t e;
    e.q1  = rst ? 1'b0  : a;
    e.q8  = rst ? RV8   : b;
    e.q64 = rst ? 64'd0 : c;
    return e;
  endfunction

  // One cycle of stimulus. Inputs change on the falling edge and the expected
  // result is queued. mode 1 glitches d and mode 2 glitches reset between
  // the following rising edge and the next falling edge (restored before the
  // falling edge), which must not disturb q.
  task automatic drive(input logic rst, input logic a, input logic [7:0] b,
                       input logic [63:0] c, input int mode);
    @(negedge clk);
    reset      = rst;
    d1         = a;
    d8         = b;
    newaddress = c;
    sb.push_back(model(rst, a, b, c));
    @(posedge clk);
    if (mode == 1) begin
      #2;
      d1 = ~a; d8 = ~b; newaddress = ~c;
      #1;
      d1 = a; d8 = b; newaddress = c;
    end else if (mode == 2) begin
      #2;
      reset = ~rst;
      #1;
      reset = rst;
    end
  endtask

  // Monitor: q is presented after every rising edge; compare against the
  // oldest queued expectation, then confirm q still holds later in the cycle.
  initial begin : monitor
    exp_t e;
    exp_t last;
    bit   have;
    have = 1'b0;
    last = '0;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("q1_edge",  {63'd0, q1},  {63'd0, e.q1});
        chk("q8_edge",  {56'd0, q8},  {56'd0, e.q8});
        chk("q64_edge", oldaddress,   e.q64);
        last = e;
        have = 1'b1;
      end
      if (have) begin
        #3;
        chk("q1_hold",  {63'd0, q1},  {63'd0, last.q1});
        chk("q8_hold",  {56'd0, q8},  {56'd0, last.q8});
        chk("q64_hold", oldaddress,   last.q64);
      end
    end
  end

  initial begin : stimulus
    reset = 1'b0; d1 = 1'b0; d8 = 8'h00; newaddress = 64'd0;

    // reset with d=1, then release with d=1
    drive(1'b1, 1'b1, 8'hFF, '1, 0);
    drive(1'b0, 1'b1, 8'h3C, 64'hDEAD_BEEF_0123_4567, 0);
    // hold d=1 for three edges while d toggles between edges
    repeat (3) drive(1'b0, 1'b1, 8'h5A, 64'hFFFF_0000_FFFF_0000, 1);
    // capture sequence 1,0,0,1
    drive(1'b0, 1'b1, 8'h01, 64'h1, 0);
    drive(1'b0, 1'b0, 8'h02, 64'h2, 0);
    drive(1'b0, 1'b0, 8'h04, 64'h4, 0);
    drive(1'b0, 1'b1, 8'h08, 64'h8, 0);
    // reset priority with q=1 and d=1
    drive(1'b1, 1'b1, 8'hFF, '1, 0);
    // reset pulse between edges must not clear q
    drive(1'b0, 1'b1, 8'hC3, 64'hAAAA_5555_AAAA_5555, 2);
    drive(1'b0, 1'b1, 8'hC3, 64'hAAAA_5555_AAAA_5555, 0);
    // 64-bit array pattern, then reset
    drive(1'b0, 1'b1, 8'h78, 64'h0000_0000_1234_5678, 0);
    drive(1'b1, 1'b0, 8'h12, 64'h0000_0000_1234_5678, 0);
    drive(1'b0, 1'b0, 8'h00, 64'h8000_0000_0000_0001, 0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
            {$urandom, $urandom}, int'($urandom_range(0, 2)));
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/d_ff.md
D_FF -- requirements
Module: d_ff

Interface
REQ-001 Parameter WIDTH, default 1: data width in bits; legal range 1..64. A 64-bit register is formed by instantiating 64 width-1 copies.
REQ-002 Parameter RESET_VAL, default 0 (all bits): value loaded into q on reset.
REQ-003 Port clk: input, 1 bit; the single clock; all state changes occur on its rising edge only.
REQ-004 Port reset: input, 1 bit; synchronous, active-high reset.
REQ-005 Port d: input, WIDTH bits; data sampled at the rising clk edge.
REQ-006 Port q: output, WIDTH bits; registered state, driven directly from flop storage with no combinational path from d, reset or clk.
REQ-007 The block SHALL have exactly one clock and a synchronous active-high reset; port names SHALL be clk, reset, d, q, so that named connection (.q, .d, .reset, .clk) binds without renaming.

Function
REQ-008 On each rising clk edge with reset=0, q SHALL take the value of d sampled at that edge.
REQ-009 Latency SHALL be one clock; a change on d between edges SHALL NOT affect q until the next rising edge.
REQ-010 Between rising edges, q SHALL hold its value regardless of activity on d or reset.
REQ-011 Each bit SHALL be independent; no bit of q SHALL depend on any other bit of d.
REQ-012 There is no enable; q reloads on every edge.
REQ-013 Simulation timescale SHALL be 1ns/10ps, matching the rest of the datapath.

Reset
REQ-014 On a rising clk edge with reset=1, q SHALL become RESET_VAL (0 by default) regardless of d.
REQ-015 Reset SHALL take priority over d when both are active at the same edge.
REQ-016 Assertion or deassertion of reset between edges SHALL NOT change q; reset is not asynchronous.
REQ-017 An edge with reset=1 followed by an edge with reset=0 SHALL give q=RESET_VAL after the first edge and q=d after the second.
REQ-018 A reset asserted mid-operation SHALL discard the stored value at the next edge, with no residual state.
REQ-019 Before the first rising edge, q is undefined (X in simulation); no power-up value is guaranteed.

Verification
REQ-020 Reset: d=1, reset=1, one rising edge -> q=0; then reset=0 with d=1, next edge -> q=1.
REQ-021 Hold: d=1 held for 3 edges -> q=1 after each edge; toggle d between edges -> q unchanged until the next edge.
REQ-022 Capture sequence: d=1,0,0,1 on successive edges -> q=1,0,0,1, each visible one edge later than d is applied.
REQ-023 Reset priority: q=1, apply reset=1 and d=1 at the same edge -> q=0.
REQ-024 Synchronous reset: pulse reset=1 between edges, low again before the next edge -> q unchanged.
REQ-025 64-bit array: drive newaddress=$random pattern, e.g. 64'h0000_0000_1234_5678, through 64 instances -> oldaddress equals the pattern after one edge, and all zeros after an edge with reset=1.
